// File: rtl/codec_init_seq_if.sv
// ---------------------------------------------------------------------------
// codec_init_seq_if
//
// Request/response bundle between the CODEC power-up sequencer and the I2C
// register controller (i2c_seq_sm).
//
//   codec_wr_en          one-cycle write request      (sequencer -> controller)
//   codec_rd_en          one-cycle read request       (sequencer -> controller)
//   codec_reg_addr [7:0] address byte {reg[6:0], data[8]}
//   codec_data_in  [7:0] write data byte
//   controller_busy      controller transfer in progress (controller -> seq)
//   codec_data_out [7:0] read data
//   codec_data_out_valid read data valid, sticky until the next request
//   missed_ack           NACK seen on the last completed transfer
//
// master: sequencer side.  slave: controller side.
// ---------------------------------------------------------------------------
interface codec_init_seq_if;
  logic       codec_wr_en;
  logic       codec_rd_en;
  logic [7:0] codec_reg_addr;
  logic [7:0] codec_data_in;
  logic       controller_busy;
  logic [7:0] codec_data_out;
  logic       codec_data_out_valid;
  logic       missed_ack;

  modport master (
    output codec_wr_en,
    output codec_rd_en,
    output codec_reg_addr,
    output codec_data_in,
    input  controller_busy,
    input  codec_data_out,
    input  codec_data_out_valid,
    input  missed_ack
  );

  modport slave (
    input  codec_wr_en,
    input  codec_rd_en,
    input  codec_reg_addr,
    input  codec_data_in,
    output controller_busy,
    output codec_data_out,
    output codec_data_out_valid,
    output missed_ack
  );
endinterface

// File: rtl/codec_init_seq.sv
// ---------------------------------------------------------------------------
// codec_init_seq
//
// Power-up configuration sequencer for the SSM2603 audio CODEC. Walks a fixed
// 10-entry register table through the i2c_seq_sm request port, writing each
// entry and reading back the ones marked for verification. A settle delay
// (VMID charge) is inserted between entry 8 and the final output-enable
// write (entry 9).
//
// Parameters
//   DELAY_CYCLES   settle delay before entry 9, in clk cycles (24 bit)
//   TIMEOUT_CYCLES max cycles per transfer, issue until busy falls (16 bit)
//
// Ports
//   clk         clock
//   reset       asynchronous reset, active low
//   start       level; accepted in IDLE / DONE / ERROR, restarts at entry 0
//   bus         codec_init_seq_if.master towards i2c_seq_sm
//   init_busy   sequence running
//   init_done   sequence completed
//   init_error  sequence aborted
//   err_code    01 missed ack, 10 readback mismatch, 11 timeout
//   err_index   table index of the failing entry
// ---------------------------------------------------------------------------
module codec_init_seq #(
  parameter logic [23:0] DELAY_CYCLES   = 24'd10_000_000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  codec_init_seq_if.master        bus,
  output logic                    init_busy,
  output logic                    init_done,
  output logic                    init_error,
  output logic [1:0]              err_code,
  output logic [3:0]              err_index
);

  typedef enum logic [3:0] {
    IDLE,
    ISSUE_WR,
    WAIT_WR_HI,
    WAIT_WR_LO,
    ISSUE_RD,
    WAIT_RD_HI,
    WAIT_RD_LO,
    CHECK,
    DELAY,
    NEXT,
    DONE,
    ERROR
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       verify;
  } entry_t;

  localparam logic [3:0] DELAY_IDX = 4'd8;
  localparam logic [3:0] LAST_IDX  = 4'd9;

  localparam logic [1:0] ERR_NACK     = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Register table. The address byte already carries data bit 8 in its LSB.
  function automatic entry_t tbl(input logic [3:0] i);
    case (i)
      4'd0:    tbl = '{addr: 8'h1E, data: 8'h00, verify: 1'b0}; // software reset
      4'd1:    tbl = '{addr: 8'h0C, data: 8'h10, verify: 1'b1}; // power: outputs off
      4'd2:    tbl = '{addr: 8'h00, data: 8'h17, verify: 1'b1}; // left line in
      4'd3:    tbl = '{addr: 8'h02, data: 8'h17, verify: 1'b1}; // right line in
      4'd4:    tbl = '{addr: 8'h08, data: 8'h12, verify: 1'b1}; // analog path
      4'd5:    tbl = '{addr: 8'h0A, data: 8'h00, verify: 1'b1}; // digital path
      4'd6:    tbl = '{addr: 8'h0E, data: 8'h02, verify: 1'b1}; // digital interface
      4'd7:    tbl = '{addr: 8'h10, data: 8'h00, verify: 1'b1}; // sampling rate
      4'd8:    tbl = '{addr: 8'h12, data: 8'h01, verify: 1'b1}; // active
      4'd9:    tbl = '{addr: 8'h0C, data: 8'h00, verify: 1'b1}; // power: outputs on
      default: tbl = '0;
    endcase
  endfunction

  state_t      state;
  logic [3:0]  idx;
  logic [15:0] tmo_cnt;
  logic [23:0] dly_cnt;
  logic        wr_en_r;
  logic        rd_en_r;
  logic [7:0]  addr_r;
  logic [7:0]  data_r;

  entry_t      cur_ent;
  entry_t      nxt_ent;
  entry_t      first_ent;
  entry_t      last_ent;
  logic        tmo_hit;
  logic [15:0] tmo_next;
  logic        dly_term;
  logic        fail_now;
  logic [1:0]  fail_code;

  assign bus.codec_wr_en    = wr_en_r;
  assign bus.codec_rd_en    = rd_en_r;
  assign bus.codec_reg_addr = addr_r;
  assign bus.codec_data_in  = data_r;

  assign cur_ent   = tbl(idx);
  assign nxt_ent   = tbl(idx + 4'd1);
  assign first_ent = tbl(4'd0);
  assign last_ent  = tbl(LAST_IDX);

  assign tmo_hit  = (tmo_cnt >= TIMEOUT_CYCLES);
  // Saturate so a very large TIMEOUT_CYCLES can never be skipped by a wrap.
  assign tmo_next = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
  // Widened compare so DELAY_CYCLES = 0 still terminates after one cycle.
  assign dly_term = ({1'b0, dly_cnt} + 25'd1) >= {1'b0, DELAY_CYCLES};

  // Abort conditions, evaluated ahead of the normal state transitions.
  always_comb begin
    fail_now  = 1'b0;
    fail_code = 2'b00;
    case (state)
      WAIT_WR_HI, WAIT_RD_HI: begin
        if (!bus.controller_busy && tmo_hit) begin
          fail_now  = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      WAIT_WR_LO, WAIT_RD_LO: begin
        if (!bus.controller_busy) begin
          if (bus.missed_ack) begin
            fail_now  = 1'b1;
            fail_code = ERR_NACK;
          end
        end else if (tmo_hit) begin
          fail_now  = 1'b1;
          fail_code = ERR_TIMEOUT;
        end
      end
      CHECK: begin
        if (!bus.codec_data_out_valid || (bus.codec_data_out != cur_ent.data)) begin
          fail_now  = 1'b1;
          fail_code = ERR_MISMATCH;
        end
      end
      default: ;
    endcase
  end

  // Request pulses are raised on the transition into ISSUE_WR / ISSUE_RD so
  // the one-cycle pulse coincides with the ISSUE state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 4'd0;
      tmo_cnt    <= 16'd0;
      dly_cnt    <= 24'd0;
      wr_en_r    <= 1'b0;
      rd_en_r    <= 1'b0;
      addr_r     <= 8'h00;
      data_r     <= 8'h00;
      init_busy  <= 1'b0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
      err_code   <= 2'b00;
      err_index  <= 4'd0;
    end else begin
      wr_en_r <= 1'b0;
      rd_en_r <= 1'b0;

      if (fail_now) begin
        state      <= ERROR;
        init_busy  <= 1'b0;
        init_error <= 1'b1;
        err_code   <= fail_code;
        err_index  <= idx;
      end else begin
        case (state)
          IDLE, DONE, ERROR: begin
            // A transfer abandoned by reset may still be running downstream;
            // its request port only listens once busy has dropped.
            if (start && !bus.controller_busy) begin
              idx        <= 4'd0;
              err_code   <= 2'b00;
              err_index  <= 4'd0;
              init_done  <= 1'b0;
              init_error <= 1'b0;
              init_busy  <= 1'b1;
              addr_r     <= first_ent.addr;
              data_r     <= first_ent.data;
              wr_en_r    <= 1'b1;
              state      <= ISSUE_WR;
            end
          end

          ISSUE_WR: begin
            tmo_cnt <= 16'd0;
            state   <= WAIT_WR_HI;
          end

          WAIT_WR_HI: begin
            tmo_cnt <= tmo_next;
            if (bus.controller_busy) state <= WAIT_WR_LO;
          end

          WAIT_WR_LO: begin
            tmo_cnt <= tmo_next;
            if (!bus.controller_busy) begin
              if (cur_ent.verify) begin
                rd_en_r <= 1'b1;
                state   <= ISSUE_RD;
              end else begin
                state <= NEXT;
              end
            end
          end

          ISSUE_RD: begin
            tmo_cnt <= 16'd0;
            state   <= WAIT_RD_HI;
          end

          WAIT_RD_HI: begin
            tmo_cnt <= tmo_next;
            if (bus.controller_busy) state <= WAIT_RD_LO;
          end

          WAIT_RD_LO: begin
            tmo_cnt <= tmo_next;
            if (!bus.controller_busy) state <= CHECK;
          end

          CHECK: begin
            state <= NEXT;
          end

          NEXT: begin
            if (idx == LAST_IDX) begin
              init_busy <= 1'b0;
              init_done <= 1'b1;
              state     <= DONE;
            end else if (idx == DELAY_IDX) begin
              dly_cnt <= 24'd0;
              state   <= DELAY;
            end else begin
              idx     <= idx + 4'd1;
              addr_r  <= nxt_ent.addr;
              data_r  <= nxt_ent.data;
              wr_en_r <= 1'b1;
              state   <= ISSUE_WR;
            end
          end

          DELAY: begin
            if (dly_term) begin
              idx     <= LAST_IDX;
              addr_r  <= last_ent.addr;
              data_r  <= last_ent.data;
              wr_en_r <= 1'b1;
              state   <= ISSUE_WR;
            end else begin
              dly_cnt <= dly_cnt + 24'd1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_codec_init_seq.sv
module tb_codec_init_seq;

  localparam int BUSY_LEN = 20;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       init_busy;
  logic       init_done;
  logic       init_error;
  logic [1:0] err_code;
  logic [3:0] err_index;

  codec_init_seq_if bus();

  codec_init_seq #(
    .DELAY_CYCLES   (24'd100),
    .TIMEOUT_CYCLES (16'd50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .init_error (init_error),
    .err_code   (err_code),
    .err_index  (err_index)
  );

  always #5 clk = ~clk;

  // Expected register table
  logic [7:0] t_addr [10] = '{8'h1E, 8'h0C, 8'h00, 8'h02, 8'h08, 8'h0A, 8'h0E, 8'h10, 8'h12, 8'h0C};
  logic [7:0] t_data [10] = '{8'h00, 8'h10, 8'h17, 8'h17, 8'h12, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00};
  bit         t_ver  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural i2c_seq_sm ----------------
  logic       m_busy  = 1'b0;
  logic       m_nack  = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_dout  = 8'h00;
  int         m_cnt   = 0;
  bit         m_is_rd = 1'b0;
  bit         m_nack_pend = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] mem [256];

  bit         k_nack = 1'b0;
  logic [7:0] k_nack_addr = 8'h00;
  bit         k_bad = 1'b0;
  logic [7:0] k_bad_addr = 8'h00;
  bit         k_hang = 1'b0;

  assign bus.controller_busy      = m_busy;
  assign bus.missed_ack           = m_nack;
  assign bus.codec_data_out       = m_dout;
  assign bus.codec_data_out_valid = m_valid;

  always @(posedge clk) begin
    if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_nack <= m_nack_pend;
        if (m_is_rd) begin
          m_dout  <= m_rdata;
          m_valid <= 1'b1;
        end
      end
    end else if (!k_hang && (bus.codec_wr_en || bus.codec_rd_en)) begin
      m_busy  <= 1'b1;
      m_cnt   <= BUSY_LEN;
      m_valid <= 1'b0;
      m_is_rd <= bus.codec_rd_en;
      if (bus.codec_wr_en) begin
        mem[bus.codec_reg_addr] <= bus.codec_data_in;
        m_nack_pend <= k_nack && (bus.codec_reg_addr == k_nack_addr);
      end else begin
        m_rdata <= (k_bad && (bus.codec_reg_addr == k_bad_addr)) ? 8'hFF : mem[bus.codec_reg_addr];
        m_nack_pend <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  // item = {wr_en, rd_en, addr, data}
  logic [17:0] exp_q [$];
  int n_wr = 0;
  int n_rd = 0;
  int t8 = 0;
  int t9 = 0;
  int cyc = 0;
  bit prev_wr = 1'b0;
  bit prev_rd = 1'b0;

  always @(negedge clk) begin
    logic [17:0] got;
    logic [17:0] e;
    cyc++;
    if (reset && (bus.codec_wr_en || bus.codec_rd_en)) begin
      got = {bus.codec_wr_en, bus.codec_rd_en, bus.codec_reg_addr, bus.codec_data_in};
      check("pulse_width", 32'({prev_wr, prev_rd}), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(got), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("txn", 32'(got), 32'(e));
      end
      if (bus.codec_wr_en) n_wr++;
      if (bus.codec_rd_en) n_rd++;
      if (bus.codec_wr_en && bus.codec_reg_addr == 8'h12) t8 = cyc;
      if (bus.codec_wr_en && bus.codec_reg_addr == 8'h0C && bus.codec_data_in == 8'h00) t9 = cyc;
    end
    prev_wr = bus.codec_wr_en;
    prev_rd = bus.codec_rd_en;
  end

  task automatic push_entries(input int last, input bit last_read);
    for (int e = 0; e <= last; e++) begin
      exp_q.push_back({1'b1, 1'b0, t_addr[e], t_data[e]});
      if (t_ver[e] && (e < last || last_read))
        exp_q.push_back({1'b0, 1'b1, t_addr[e], t_data[e]});
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_wr_en", 32'(bus.codec_wr_en), 32'd1);
    check("start_busy", 32'(init_busy), 32'd1);
  endtask

  task automatic wait_end(input int budget, input bit jitter);
    int k;
    k = 0;
    while (!(init_done || init_error) && k < budget) begin
      @(negedge clk);
      if (jitter && init_busy && n_wr < 9) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      k++;
    end
    start = 1'b0;
    check("end_reached", 32'(init_done || init_error), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_busy"},  32'(init_busy),  32'd0);
    check({tag, "_done"},  32'(init_done),  32'd0);
    check({tag, "_error"}, 32'(init_error), 32'd0);
    check({tag, "_code"},  32'(err_code),   32'd0);
    check({tag, "_index"}, 32'(err_index),  32'd0);
    check({tag, "_pulses"}, 32'({bus.codec_wr_en, bus.codec_rd_en}), 32'd0);
    check({tag, "_addr"},  32'(bus.codec_reg_addr), 32'd0);
    check({tag, "_data"},  32'(bus.codec_data_in),  32'd0);
  endtask

  task automatic full_pass(input string tag, input bit jitter);
    n_wr = 0; n_rd = 0; t8 = 0; t9 = 0;
    push_entries(9, 1'b1);
    do_start();
    check({tag, "_err_cleared"}, 32'(init_error), 32'd0);
    check({tag, "_done_cleared"}, 32'(init_done), 32'd0);
    wait_end(4000, jitter);
    check({tag, "_done"},  32'(init_done),  32'd1);
    check({tag, "_error"}, 32'(init_error), 32'd0);
    check({tag, "_busy"},  32'(init_busy),  32'd0);
    check({tag, "_q"},     32'(exp_q.size()), 32'd0);
    check({tag, "_n_wr"},  32'(n_wr), 32'd10);
    check({tag, "_n_rd"},  32'(n_rd), 32'd9);
    check({tag, "_delay_gap_ok"}, 32'((t9 - t8) >= 140 && (t9 - t8) <= 150), 32'd1);
  endtask

  initial begin
    int k;
    // Reset state
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Full pass with start toggled mid-sequence
    full_pass("pass1", 1'b1);

    // Missed ack on entry 3 write
    k_nack = 1'b1; k_nack_addr = 8'h02;
    exp_q.delete();
    push_entries(3, 1'b0);
    do_start();
    wait_end(4000, 1'b0);
    check("nack_error", 32'(init_error), 32'd1);
    check("nack_code",  32'(err_code),   32'd1);
    check("nack_index", 32'(err_index),  32'd3);
    check("nack_done",  32'(init_done),  32'd0);
    check("nack_busy",  32'(init_busy),  32'd0);
    repeat (100) @(negedge clk);
    check("nack_q", 32'(exp_q.size()), 32'd0);
    k_nack = 1'b0;

    // Restart from ERROR
    full_pass("restart", 1'b0);

    // Readback mismatch on entry 5
    k_bad = 1'b1; k_bad_addr = 8'h0A;
    exp_q.delete();
    push_entries(5, 1'b1);
    do_start();
    wait_end(4000, 1'b0);
    check("mm_error", 32'(init_error), 32'd1);
    check("mm_code",  32'(err_code),   32'd2);
    check("mm_index", 32'(err_index),  32'd5);
    repeat (50) @(negedge clk);
    check("mm_q", 32'(exp_q.size()), 32'd0);
    k_bad = 1'b0;

    // Timeout: downstream never raises busy
    k_hang = 1'b1;
    exp_q.delete();
    push_entries(0, 1'b0);
    do_start();
    k = 1;
    while (!init_error && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("tmo_window_ok", 32'(k >= 50 && k <= 54), 32'd1);
    check("tmo_code",  32'(err_code),  32'd3);
    check("tmo_index", 32'(err_index), 32'd0);
    repeat (60) @(negedge clk);
    check("tmo_q", 32'(exp_q.size()), 32'd0);
    k_hang = 1'b0;

    // Reset during entry 4
    exp_q.delete();
    n_wr = 0;
    push_entries(4, 1'b0);
    do_start();
    k = 0;
    while (n_wr < 5 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("reach_entry4", 32'(n_wr >= 5), 32'd1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1 chk_zero("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("midrst_q", 32'(exp_q.size()), 32'd0);
    check("midrst_idle_busy", 32'(init_busy), 32'd0);

    // Clean pass after reset
    exp_q.delete();
    full_pass("post_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
